// File: rtl/lc3b_types.sv
// Shared types for the memory-hierarchy interconnect: arbiter state/mode
// encodings and default L2 line address/data widths.
package lc3b_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  typedef logic [27:0]  lc3b_line_addr;
  typedef logic [127:0] lc3b_line_data;

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker: first requester found scanning upward from
// start (round-robin) or from index 0 (fixed priority), with wrap-around.
module rr_pick
  import lc3b_types::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  input  arb_mode_t     mode,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx,
  output logic          found
);

  always_comb begin
    int base;
    int j;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    base  = (mode == ARB_FIXED) ? 0 : int'(start);
    for (int k = 0; k < N; k++) begin
      j = (base + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        idx    = PW'(j);
        win[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave wishbone arbiter: one owner per transaction, held until
// ACK/RTY/abort, followed by a single turnaround cycle.
module wb_rr_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_MASTERS   = 2,
  parameter int ADDR_WIDTH    = 28,
  parameter int DATA_WIDTH    = 128,
  parameter int SEL_WIDTH     = DATA_WIDTH / 8,
  parameter int PRIORITY_MODE = 0
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [NUM_MASTERS-1:0]            m_cyc,
  input  logic [NUM_MASTERS-1:0]            m_stb,
  input  logic [NUM_MASTERS-1:0]            m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic [NUM_MASTERS-1:0]            m_rty,
  output logic [DATA_WIDTH-1:0]             m_dat_s,
  output logic                              s_cyc,
  output logic                              s_stb,
  output logic                              s_we,
  output logic [ADDR_WIDTH-1:0]             s_adr,
  output logic [DATA_WIDTH-1:0]             s_dat,
  output logic [SEL_WIDTH-1:0]              s_sel,
  input  logic                              s_ack,
  input  logic                              s_rty,
  input  logic [DATA_WIDTH-1:0]             s_dat_s,
  output logic [NUM_MASTERS-1:0]            grant
);

  localparam int        PW   = $clog2(NUM_MASTERS);
  localparam arb_mode_t MODE = (PRIORITY_MODE != 0) ? ARB_FIXED : ARB_RR;

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] req, pick_win;
  logic [PW-1:0]          last_ptr, start, pick_idx;
  logic                   pick_found;
  logic                   busy, done;

  assign req  = m_cyc & m_stb;
  assign busy = (state == BUSY);
  // Owner dropping CYC or STB counts as an abort and ends the tenure.
  assign done = s_ack | s_rty | ((grant & req) == '0);

  // Explicit wrap keeps start in range for non-power-of-two master counts.
  assign start = (last_ptr == PW'(NUM_MASTERS - 1)) ? '0 : last_ptr + 1'b1;

  rr_pick #(
    .N  (NUM_MASTERS),
    .PW (PW)
  ) u_pick (
    .req   (req),
    .start (start),
    .mode  (MODE),
    .win   (pick_win),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = BUSY;
      BUSY:    if (done) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      grant    <= '0;
      last_ptr <= PW'(NUM_MASTERS - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_found) begin
        grant    <= pick_win;
        last_ptr <= pick_idx;
      end else if (busy && done) begin
        grant <= '0;
      end
    end
  end

  // grant is one-hot and only non-zero while BUSY, so an OR-mux suffices.
  always_comb begin
    s_we  = 1'b0;
    s_adr = '0;
    s_dat = '0;
    s_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (busy && grant[i]) begin
        s_we  = s_we  | m_we[i];
        s_adr = s_adr | m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_dat = s_dat | m_dat[i*DATA_WIDTH +: DATA_WIDTH];
        s_sel = s_sel | m_sel[i*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  assign s_cyc   = busy;
  assign s_stb   = busy;
  assign m_ack   = grant & {NUM_MASTERS{s_ack & busy}};
  assign m_rty   = grant & {NUM_MASTERS{s_rty & busy}};
  assign m_dat_s = s_dat_s;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: a round-robin and a fixed-priority instance share
// the master side and are compared every cycle against a transaction model.
module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int SW = 16;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;

  logic [N-1:0]  m_ack [2];
  logic [N-1:0]  m_rty [2];
  logic [N-1:0]  grant [2];
  logic [DW-1:0] m_dat_s [2];
  logic [DW-1:0] s_dat [2];
  logic [DW-1:0] s_dat_s [2];
  logic [AW-1:0] s_adr [2];
  logic [SW-1:0] s_sel [2];
  logic          s_cyc [2];
  logic          s_stb [2];
  logic          s_we [2];
  logic          s_ack [2];
  logic          s_rty [2];

  int n_chk = 0;
  int n_fail = 0;

  // Model: current owner (-1 when none), turnaround flag, last granted index.
  int owner [2];
  int last [2];
  bit rel [2];

  always #5 CLK = ~CLK;

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .PRIORITY_MODE(0)
  ) u_rr (
    .CLK(CLK), .RST_N(RST_N),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat(m_dat), .m_sel(m_sel),
    .m_ack(m_ack[0]), .m_rty(m_rty[0]), .m_dat_s(m_dat_s[0]),
    .s_cyc(s_cyc[0]), .s_stb(s_stb[0]), .s_we(s_we[0]), .s_adr(s_adr[0]),
    .s_dat(s_dat[0]), .s_sel(s_sel[0]),
    .s_ack(s_ack[0]), .s_rty(s_rty[0]), .s_dat_s(s_dat_s[0]),
    .grant(grant[0])
  );

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .PRIORITY_MODE(1)
  ) u_fix (
    .CLK(CLK), .RST_N(RST_N),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat(m_dat), .m_sel(m_sel),
    .m_ack(m_ack[1]), .m_rty(m_rty[1]), .m_dat_s(m_dat_s[1]),
    .s_cyc(s_cyc[1]), .s_stb(s_stb[1]), .s_we(s_we[1]), .s_adr(s_adr[1]),
    .s_dat(s_dat[1]), .s_sel(s_sel[1]),
    .s_ack(s_ack[1]), .s_rty(s_rty[1]), .s_dat_s(s_dat_s[1]),
    .grant(grant[1])
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_dat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Instance 1 is fixed priority; instance 0 scans upward from last+1.
  function automatic int pick(input int k, input logic [N-1:0] r);
    if (k == 1) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else begin
      for (int d = 1; d <= N; d++) if (r[(last[k] + d) % N]) return (last[k] + d) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      rel[k]   = 1'b0;
      last[k]  = N - 1;
    end
  endtask

  task automatic model_update();
    logic [N-1:0] r;
    int w;
    r = m_cyc & m_stb;
    for (int k = 0; k < 2; k++) begin
      if (!RST_N) begin
        owner[k] = -1;
        rel[k]   = 1'b0;
        last[k]  = N - 1;
      end else if (owner[k] >= 0) begin
        if (s_ack[k] || s_rty[k] || !r[owner[k]]) begin
          owner[k] = -1;
          rel[k]   = 1'b1;
        end
      end else if (rel[k]) begin
        rel[k] = 1'b0;
      end else begin
        w = pick(k, r);
        if (w >= 0) begin
          owner[k] = w;
          last[k]  = w;
        end
      end
    end
  endtask

  task automatic compare_all();
    bit b;
    int o;
    logic [N-1:0] g;
    string p;
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? "rr" : "fix";
      b = (owner[k] >= 0);
      o = b ? owner[k] : 0;
      g = b ? (N'(1) << o) : '0;
      chk({p, ".s_cyc"}, DW'(s_cyc[k]), DW'(b));
      chk({p, ".s_stb"}, DW'(s_stb[k]), DW'(b));
      chk({p, ".grant"}, DW'(grant[k]), DW'(g));
      chk({p, ".s_we"}, DW'(s_we[k]), DW'(b ? m_we[o] : 1'b0));
      chk({p, ".s_adr"}, DW'(s_adr[k]), DW'(b ? m_adr[o*AW +: AW] : '0));
      chk({p, ".s_dat"}, s_dat[k], b ? m_dat[o*DW +: DW] : '0);
      chk({p, ".s_sel"}, DW'(s_sel[k]), DW'(b ? m_sel[o*SW +: SW] : '0));
      chk({p, ".m_ack"}, DW'(m_ack[k]), DW'((b && s_ack[k]) ? g : '0));
      chk({p, ".m_rty"}, DW'(m_rty[k]), DW'((b && s_rty[k]) ? g : '0));
      chk({p, ".m_dat_s"}, m_dat_s[k], s_dat_s[k]);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    compare_all();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a);
    m_cyc[i] = v;
    m_stb[i] = v;
    if (v) begin
      m_adr[i*AW +: AW] = a;
      m_dat[i*DW +: DW] = rnd_dat();
      m_sel[i*SW +: SW] = SW'($urandom());
      m_we[i]           = 1'($urandom());
    end
  endtask

  task automatic slave(input bit a, input bit r);
    for (int k = 0; k < 2; k++) begin
      s_ack[k] = a;
      s_rty[k] = r;
    end
  endtask

  task automatic drop_all_and_idle();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0);
    slave(1'b0, 1'b0);
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] q0 [$];
    logic [N-1:0] q1 [$];
    bit r [N];
    bit seen;

    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat = '0; m_sel = '0;
    for (int k = 0; k < 2; k++) begin
      s_ack[k] = 1'b0; s_rty[k] = 1'b0; s_dat_s[k] = '0;
    end
    model_reset();
    @(negedge CLK);

    // Reset state, including a request pending under reset.
    step();
    set_req(0, 1'b1, 28'h0ABCDEF);
    step();
    set_req(0, 1'b0, '0);
    RST_N = 1'b1;
    step();

    // Single read through both instances.
    set_req(0, 1'b1, 28'h1234567);
    step();
    #1 chk("rd.s_stb", DW'(s_stb[0]), DW'(1'b1));
    chk("rd.s_adr", DW'(s_adr[0]), DW'(28'h1234567));
    step();
    step();
    slave(1'b1, 1'b0);
    s_dat_s[0] = 128'hDEADBEEF_00112233_44556677_8899AABB;
    s_dat_s[1] = s_dat_s[0];
    #1 chk("rd.m_ack", DW'(m_ack[0]), DW'(4'b0001));
    chk("rd.m_dat_s", m_dat_s[0], 128'hDEADBEEF_00112233_44556677_8899AABB);
    step();
    slave(1'b0, 1'b0);
    set_req(0, 1'b0, '0);
    #1 chk("rd.s_stb_off", DW'(s_stb[0]), DW'(1'b0));
    step();
    step();

    // Contention between masters 0 and 1 with a zero-wait slave.
    set_req(0, 1'b1, 28'h0000100);
    set_req(1, 1'b1, 28'h0000200);
    slave(1'b1, 1'b0);
    q0.delete(); q1.delete();
    repeat (12) begin
      #1;
      if (grant[0] != '0) q0.push_back(grant[0]);
      if (grant[1] != '0) q1.push_back(grant[1]);
      step();
    end
    chk("cont.n_rr", DW'(q0.size()), DW'(4));
    chk("cont.n_fix", DW'(q1.size()), DW'(4));
    foreach (q0[i]) chk("cont.rr_seq", DW'(q0[i]), DW'((i % 2 == 0) ? 4'b0010 : 4'b0001));
    foreach (q1[i]) chk("cont.fix_seq", DW'(q1[i]), DW'(4'b0001));
    drop_all_and_idle();

    // Fixed priority: masters 0 and 3, then master 0 withdraws.
    set_req(0, 1'b1, 28'h0000300);
    set_req(3, 1'b1, 28'h0000400);
    slave(1'b1, 1'b0);
    q1.delete();
    repeat (15) begin
      #1;
      if (grant[1] != '0) q1.push_back(grant[1]);
      step();
    end
    chk("fix.n", DW'(q1.size()), DW'(5));
    foreach (q1[i]) chk("fix.grant0", DW'(q1[i]), DW'(4'b0001));
    set_req(0, 1'b0, '0);
    seen = 1'b0;
    repeat (6) begin
      #1;
      if (!seen && grant[1] != '0) begin
        seen = 1'b1;
        chk("fix.grant3", DW'(grant[1]), DW'(4'b1000));
      end
      step();
    end
    chk("fix.grant3_seen", DW'(seen), DW'(1'b1));
    drop_all_and_idle();

    // Retry for master 1, then master 0 wins the re-arbitration.
    set_req(1, 1'b1, 28'h0000500);
    step();
    slave(1'b0, 1'b1);
    set_req(0, 1'b1, 28'h0000600);
    #1 chk("rty.m_rty", DW'(m_rty[0]), DW'(4'b0010));
    chk("rty.m_ack", DW'(m_ack[0]), DW'(4'b0000));
    step();
    slave(1'b0, 1'b0);
    step();
    step();
    #1 chk("rty.regrant", DW'(grant[0]), DW'(4'b0001));
    slave(1'b1, 1'b0);
    step();
    drop_all_and_idle();

    // Abort: master 1 drops STB on its second BUSY cycle, late ACK ignored.
    set_req(1, 1'b1, 28'h0000700);
    step();
    step();
    m_stb[1] = 1'b0;
    step();
    slave(1'b1, 1'b0);
    #1 chk("abort.s_stb", DW'(s_stb[0]), DW'(1'b0));
    chk("abort.m_ack", DW'(m_ack[0]), DW'(4'b0000));
    step();
    drop_all_and_idle();

    // Asynchronous reset while BUSY.
    set_req(2, 1'b1, 28'h0000800);
    step();
    #3 RST_N = 1'b0;
    #1 chk("arst.s_cyc", DW'(s_cyc[0]), DW'(1'b0));
    chk("arst.s_stb", DW'(s_stb[0]), DW'(1'b0));
    chk("arst.grant_rr", DW'(grant[0]), DW'(4'b0000));
    chk("arst.grant_fix", DW'(grant[1]), DW'(4'b0000));
    model_reset();
    @(negedge CLK);
    set_req(2, 1'b0, '0);
    set_req(0, 1'b1, 28'h0000900);
    set_req(1, 1'b1, 28'h0000A00);
    RST_N = 1'b1;
    step();
    #1 chk("arst.first_grant", DW'(grant[0]), DW'(4'b0001));
    slave(1'b1, 1'b0);
    step();
    drop_all_and_idle();

    // Randomized traffic with sticky requests, glitches and random slaves.
    for (int i = 0; i < N; i++) r[i] = 1'b0;
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) begin
          r[i] = !r[i];
          if (r[i]) set_req(i, 1'b1, AW'($urandom()));
        end else if (r[i] && $urandom_range(3) == 0) begin
          m_adr[i*AW +: AW] = AW'($urandom());
          m_dat[i*DW +: DW] = rnd_dat();
        end
        m_cyc[i] = r[i] | ($urandom_range(15) == 0);
        m_stb[i] = r[i] | ($urandom_range(15) == 0);
      end
      for (int k = 0; k < 2; k++) begin
        s_ack[k]   = ($urandom_range(3) == 0);
        s_rty[k]   = ($urandom_range(7) == 0);
        s_dat_s[k] = rnd_dat();
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
Parametrised N-master to 1-slave wishbone arbiter for the memory hierarchy. It replaces the fixed two-port icache/dcache merge in front of L2 and generalises to any number of L1 clients (icache, dcache, prefetcher, DMA). It grants one master per transaction, selected by round-robin or fixed priority. The granted master owns the slave port until ACK, RTY or abort, then a one-cycle turnaround returns the block to idle.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_WIDTH, 28, line address width (ADR)
DATA_WIDTH, 128, data bus width
SEL_WIDTH, DATA_WIDTH/8, byte-select width
PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed priority, lowest index wins

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
m_cyc  in  NUM_MASTERS  per-master CYC
m_stb  in  NUM_MASTERS  per-master STB
m_we  in  NUM_MASTERS  per-master WE
m_adr  in  NUM_MASTERS*ADDR_WIDTH  packed per-master ADR, master i at slice i
m_dat  in  NUM_MASTERS*DATA_WIDTH  packed per-master DAT_M
m_sel  in  NUM_MASTERS*SEL_WIDTH  packed per-master SEL
m_ack  out  NUM_MASTERS  per-master ACK
m_rty  out  NUM_MASTERS  per-master RTY
m_dat_s  out  DATA_WIDTH  slave read data, broadcast to all masters
s_cyc, s_stb, s_we  out  1 each  slave-side controls
s_adr  out  ADDR_WIDTH  slave ADR
s_dat  out  DATA_WIDTH  slave DAT_M
s_sel  out  SEL_WIDTH  slave SEL
s_ack, s_rty  in  1 each  slave ACK / RTY
s_dat_s  in  DATA_WIDTH  slave read data
grant  out  NUM_MASTERS  one-hot current owner (debug/perf)

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RST_N.
- Request definition: master i requests when m_cyc[i] & m_stb[i].
- FSM states:
  - IDLE to BUSY on the first edge with any request. The winner is latched into grant and the pointer updates.
  - BUSY to RELEASE on s_ack, on s_rty, or when the granted master drops its request (abort).
  - RELEASE to IDLE unconditionally.
- Latency: a request first seen in cycle t drives s_cyc/s_stb high in cycle t+1. Minimum transaction is 3 cycles, request edge to IDLE, with a zero-wait slave.
- Slave outputs:
  - s_cyc = s_stb = (state==BUSY).
  - s_we/s_adr/s_dat/s_sel are a combinational mux of the granted master's lines while BUSY, and forced to 0 otherwise.
- Response routing:
  - m_ack[i] = s_ack & grant[i] & BUSY; m_rty likewise with s_rty.
  - m_dat_s = s_dat_s, unqualified.
  - s_ack/s_rty outside BUSY are ignored.
- Round-robin:
  - last_ptr (clog2 width) holds the index of the last grant.
  - The search starts at last_ptr+1 mod NUM_MASTERS and wraps. The first requester found wins; last_ptr <= winner.
  - Wrap case: last_ptr = NUM_MASTERS-1 makes the search start at 0.
- Fixed mode: the lowest requesting index wins; last_ptr is still updated but not used.
- Abort while BUSY: slave strobes drop next cycle (RELEASE). No m_ack is generated. A later s_ack is ignored.
- Simultaneous s_ack and s_rty: both are forwarded; the FSM goes to RELEASE.
- Requests during BUSY/RELEASE are held off; the requesting master simply waits with STB high.
- A grant never changes mid-transaction.
- Reset values: state IDLE, grant 0, last_ptr NUM_MASTERS-1 (so master 0 wins first), all s_* outputs 0, m_ack/m_rty 0. Reset mid-BUSY drops s_cyc/s_stb immediately (asynchronous).
- No buffering of data; the arbiter adds no latency on the response path.

Decomposition:
- Shared package lc3b_types holds:
  - arb_state_t enum {IDLE, BUSY, RELEASE}.
  - arb_mode_t enum {ARB_RR, ARB_FIXED}.
  - lc3b_line_addr / lc3b_line_data typedefs for the 28/128-bit defaults.
- Sub-module rr_pick: purely combinational. Inputs are req[N], start index and mode; outputs are one-hot win and index. It is reused by future multi-bank interconnects.

Test Plan:
- Single read, N=2 RR:
  - Stimulus: m_cyc/stb[0]=1, adr 0x1234567 at cycle 0; slave s_ack with s_dat_s=0xDEADBEEF... at cycle 3.
  - Response: s_stb=1, s_adr=0x1234567 in cycles 1-3; m_ack=2'b01 in cycle 3 only; s_stb=0 in cycle 4; IDLE in cycle 5.
- Contention, RR N=2:
  - Stimulus: both masters request continuously.
  - Response: grant sequence 01,10,01,10; each grant is separated by exactly one RELEASE cycle; m_ack never goes to the non-granted master.
- Fixed priority, N=4, PRIORITY_MODE=1:
  - Stimulus: masters 0 and 3 request continuously for 5 transactions.
  - Response: all 5 grants go to 0. Once master 0 drops, the next grant goes to 3.
- Retry:
  - Stimulus: slave answers s_rty for master 1.
  - Response: m_rty=2'b10 for one cycle, RELEASE, then re-arbitration; with master 0 also requesting, master 0 wins next (RR).
- Abort:
  - Stimulus: granted master 1 drops m_stb in cycle 2 of BUSY; slave s_ack arrives 1 cycle later.
  - Response: s_stb=0 next cycle; m_ack stays 0.
- Async reset:
  - Stimulus: RST_N low mid-BUSY, between clock edges.
  - Response: s_cyc/s_stb/grant go to 0 immediately. After release, simultaneous requests from masters 0 and 1 grant master 0 first.
